// File: rtl/pmt_count_serializer_if.sv
// pmt_count_serializer_if
//   Bundles the count-source and UART-side signals of the PMT count
//   serializer. The serializer connects through the slave modport. The
//   counter logic and UART (or a bench standing in for them) connect
//   through the master modport.
//   count_valid/count_data/count_ready : count word input side
//   transmit/tx_byte/tx_busy/tx_done   : UART byte handshake
//   overflow/dropped_count/frame_active: status
interface pmt_count_serializer_if;
  logic        count_valid;
  logic [15:0] count_data;
  logic        count_ready;
  logic        transmit;
  logic [7:0]  tx_byte;
  logic        tx_busy;
  logic        tx_done;
  logic        overflow;
  logic [7:0]  dropped_count;
  logic        frame_active;

  modport slave (
    input  count_valid, count_data, tx_busy, tx_done,
    output count_ready, transmit, tx_byte, overflow, dropped_count, frame_active
  );

  modport master (
    output count_valid, count_data, tx_busy, tx_done,
    input  count_ready, transmit, tx_byte, overflow, dropped_count, frame_active
  );
endinterface

// File: rtl/pmt_count_serializer.sv
// pmt_count_serializer
//   Buffers 16-bit timebin counts in a small FIFO and sends each one to the
//   UART as a 3-byte frame: SYNC_BYTE, count[15:8], count[7:0]. Bytes are
//   sent one at a time using the transmit / tx_done handshake.
//   clk : master clock, shared with the UART
//   rst : synchronous active-high reset
//   bus : pmt_count_serializer_if.slave (count input, UART handshake, status)
//
//   state       | meaning
//   ------------+------------------------------------------------------------
//   S_IDLE      | waiting for a queued count and an idle UART; pops the head
//   S_SEND      | registers transmit=1 and the byte selected by r_idx
//   S_WAIT_DONE | holds tx_byte and waits for tx_done, then next byte or IDLE
module pmt_count_serializer #(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  pmt_count_serializer_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SEND      = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;

  logic [15:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_overflow;
  logic [7:0]      r_dropped;

  logic [15:0]     r_hold, w_hold_nxt;
  logic [1:0]      r_idx, w_idx_nxt;
  logic            r_frame_active, w_frame_active_nxt;
  logic            r_transmit, w_transmit_nxt;
  logic [7:0]      r_tx_byte, w_tx_byte_nxt;

  logic            w_full, w_empty, w_push, w_drop, w_pop;
  logic [15:0]     w_head;

  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  // Full is judged on the registered occupancy, so a pop in the same cycle
  // cannot make room for a push.
  assign w_push  = bus.count_valid && !w_full;
  assign w_drop  = bus.count_valid && w_full;
  assign w_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.count_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_dropped  <= 8'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_dropped != 8'hFF) r_dropped <= r_dropped + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_hold         <= 16'd0;
      r_idx          <= 2'd0;
      r_frame_active <= 1'b0;
      r_transmit     <= 1'b0;
      r_tx_byte      <= 8'd0;
    end else begin
      r_state        <= w_state_nxt;
      r_hold         <= w_hold_nxt;
      r_idx          <= w_idx_nxt;
      r_frame_active <= w_frame_active_nxt;
      r_transmit     <= w_transmit_nxt;
      r_tx_byte      <= w_tx_byte_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_pop              = 1'b0;
    w_hold_nxt         = r_hold;
    w_idx_nxt          = r_idx;
    w_frame_active_nxt = r_frame_active;
    w_transmit_nxt     = 1'b0;
    w_tx_byte_nxt      = r_tx_byte;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && !bus.tx_busy) begin
          w_pop              = 1'b1;
          w_hold_nxt         = w_head;
          w_idx_nxt          = 2'd0;
          w_frame_active_nxt = 1'b1;
          w_state_nxt        = S_SEND;
        end
      end
      S_SEND: begin
        w_transmit_nxt = 1'b1;
        case (r_idx)
          2'd1:    w_tx_byte_nxt = r_hold[15:8];
          2'd2:    w_tx_byte_nxt = r_hold[7:0];
          default: w_tx_byte_nxt = SYNC_BYTE;
        endcase
        w_state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (bus.tx_done) begin
          if (r_idx == 2'd2) begin
            w_frame_active_nxt = 1'b0;
            w_state_nxt        = S_IDLE;
          end else begin
            w_idx_nxt   = r_idx + 2'd1;
            w_state_nxt = S_SEND;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.count_ready   = !w_full;
  assign bus.transmit      = r_transmit;
  assign bus.tx_byte       = r_tx_byte;
  assign bus.overflow      = r_overflow;
  assign bus.dropped_count = r_dropped;
  assign bus.frame_active  = r_frame_active;

endmodule

// File: tb/tb_pmt_count_serializer.sv
// tb_pmt_count_serializer
//   Directed bench for pmt_count_serializer. A small UART model inside the
//   run task answers each transmit with tx_done three cycles later and
//   records every byte together with the cycle in which it was sent.
module tb_pmt_count_serializer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pmt_count_serializer_if bus();

  pmt_count_serializer #(.FIFO_DEPTH(16), .SYNC_BYTE(8'hA5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] push_q[$];
  logic [7:0]  got_q[$];
  int          tx_cyc_q[$];
  bit          hold_busy      = 1'b0;
  bit          stretch_done   = 1'b0;
  bit          stretch_pend   = 1'b0;
  int          busy_cnt       = 0;
  int          fbyte          = 0;
  int          last_done_cyc  = -1;
  int          extra_done_cyc = -1;
  bit          fa_at_done     = 1'b0;

  task automatic model_reset();
    busy_cnt      = 0;
    fbyte         = 0;
    last_done_cyc = -1;
    stretch_pend  = 1'b0;
    hold_busy     = 1'b0;
    bus.tx_busy   = 1'b0;
    bus.tx_done   = 1'b0;
    got_q.delete();
    tx_cyc_q.delete();
  endtask

  // nbytes=0: run exactly budget cycles. Otherwise stop after the nbytes-th
  // tx_done (plus one cycle), or right at the nbytes-th transmit if stop_on_tx.
  task automatic run(input int nbytes, input int budget, input bit stop_on_tx);
    int seen  = 0;
    int dones = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      bus.tx_done  = stretch_pend;
      stretch_pend = 1'b0;
      if (push_q.size() > 0) begin
        bus.count_valid = 1'b1;
        bus.count_data  = push_q.pop_front();
      end else begin
        bus.count_valid = 1'b0;
      end
      if (bus.transmit === 1'b1) begin
        got_q.push_back(bus.tx_byte);
        tx_cyc_q.push_back(cyc);
        if (fbyte != 0) begin
          n_checks++;
          if (cyc !== last_done_cyc + 2) begin
            n_fail++;
            $display("FAIL tx_gap: transmit at cycle %0d, expected cycle %0d", cyc, last_done_cyc + 2);
          end
        end
        fbyte       = (fbyte + 1) % 3;
        seen++;
        busy_cnt    = 3;
        bus.tx_busy = 1'b1;
        if (stop_on_tx && seen == nbytes) return;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          bus.tx_done   = 1'b1;
          bus.tx_busy   = hold_busy;
          last_done_cyc = cyc;
          fa_at_done    = bus.frame_active;
          stretch_pend  = stretch_done;
          dones++;
        end
      end else begin
        bus.tx_busy = hold_busy;
      end
      if (cyc == extra_done_cyc) bus.tx_done = 1'b1;
      if (nbytes > 0 && !stop_on_tx && dones == nbytes) begin
        @(negedge clk);
        bus.tx_done     = 1'b0;
        bus.count_valid = 1'b0;
        stretch_pend    = 1'b0;
        return;
      end
    end
    bus.count_valid = 1'b0;
    if (nbytes > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL run_timeout: %0d transmits, %0d dones, wanted %0d bytes", seen, dones, nbytes);
    end
  endtask

  task automatic test_reset();
    rst             = 1'b1;
    bus.count_valid = 1'b0;
    bus.count_data  = 16'd0;
    model_reset();
    repeat (2) @(negedge clk);
    n_checks += 6;
    if (bus.transmit !== 1'b0)      begin n_fail++; $display("FAIL reset_transmit: got %b want 0", bus.transmit); end
    if (bus.tx_byte !== 8'h00)      begin n_fail++; $display("FAIL reset_tx_byte: got %h want 00", bus.tx_byte); end
    if (bus.overflow !== 1'b0)      begin n_fail++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
    if (bus.dropped_count !== 8'd0) begin n_fail++; $display("FAIL reset_dropped: got %0d want 0", bus.dropped_count); end
    if (bus.frame_active !== 1'b0)  begin n_fail++; $display("FAIL reset_frame_active: got %b want 0", bus.frame_active); end
    if (bus.count_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_count_ready: got %b want 1", bus.count_ready); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [7:0] exp[$] = '{8'hA5, 8'h12, 8'h34};
    int push_cyc;
    model_reset();
    push_q.push_back(16'h1234);
    push_cyc = cyc + 1;
    run(3, 200, 1'b0);
    n_checks++;
    if (got_q.size() !== 3) begin n_fail++; $display("FAIL single_count: got %0d bytes want 3", got_q.size()); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (got_q[i] !== exp[i]) begin n_fail++; $display("FAIL single_byte%0d: got %h want %h", i, got_q[i], exp[i]); end
    end
    n_checks += 3;
    if (tx_cyc_q[0] !== push_cyc + 3) begin n_fail++; $display("FAIL single_latency: first transmit at %0d want %0d", tx_cyc_q[0], push_cyc + 3); end
    if (fa_at_done !== 1'b1)          begin n_fail++; $display("FAIL single_fa_before: got %b want 1", fa_at_done); end
    if (bus.frame_active !== 1'b0)    begin n_fail++; $display("FAIL single_fa_after: got %b want 0", bus.frame_active); end
    run(0, 10, 1'b0);
    n_checks++;
    if (got_q.size() !== 3) begin n_fail++; $display("FAIL single_extra: got %0d bytes want 3", got_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp[$] = '{8'hA5, 8'h00, 8'h01, 8'hA5, 8'h00, 8'hFF,
                           8'hA5, 8'h80, 8'h00, 8'hA5, 8'hFF, 8'hFF};
    model_reset();
    push_q = '{16'h0001, 16'h00FF, 16'h8000, 16'hFFFF};
    run(12, 400, 1'b0);
    n_checks++;
    if (got_q.size() !== 12) begin n_fail++; $display("FAIL b2b_count: got %0d bytes want 12", got_q.size()); end
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (got_q[i] !== exp[i]) begin n_fail++; $display("FAIL b2b_byte%0d: got %h want %h", i, got_q[i], exp[i]); end
    end
    n_checks++;
    if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_overflow: got %b want 0", bus.overflow); end
  endtask

  task automatic test_full();
    logic [15:0] w;
    model_reset();
    hold_busy   = 1'b1;
    bus.tx_busy = 1'b1;
    for (int i = 0; i < 15; i++) push_q.push_back(16'h0100 + 16'(i));
    run(0, 17, 1'b0);
    n_checks++;
    if (bus.count_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready15: got %b want 1", bus.count_ready); end
    push_q.push_back(16'h010F);
    run(0, 2, 1'b0);
    n_checks++;
    if (bus.count_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready16: got %b want 0", bus.count_ready); end
    push_q = '{16'hDEAD, 16'hBEEF};
    run(0, 4, 1'b0);
    n_checks += 3;
    if (bus.overflow !== 1'b1)      begin n_fail++; $display("FAIL full_overflow: got %b want 1", bus.overflow); end
    if (bus.dropped_count !== 8'd2) begin n_fail++; $display("FAIL full_dropped: got %0d want 2", bus.dropped_count); end
    if (got_q.size() !== 0)         begin n_fail++; $display("FAIL full_busy_tx: got %0d bytes want 0", got_q.size()); end
    hold_busy = 1'b0;
    run(48, 3000, 1'b0);
    n_checks++;
    if (got_q.size() !== 48) begin n_fail++; $display("FAIL full_drain_count: got %0d bytes want 48", got_q.size()); end
    for (int i = 0; i < 16; i++) begin
      w = 16'h0100 + 16'(i);
      n_checks++;
      if (got_q[3*i] !== 8'hA5 || got_q[3*i+1] !== w[15:8] || got_q[3*i+2] !== w[7:0]) begin
        n_fail++;
        $display("FAIL full_word%0d: got %h %h %h want a5 %h %h", i, got_q[3*i], got_q[3*i+1], got_q[3*i+2], w[15:8], w[7:0]);
      end
    end
  endtask

  task automatic test_saturate();
    model_reset();
    hold_busy   = 1'b1;
    bus.tx_busy = 1'b1;
    for (int i = 0; i < 216; i++) push_q.push_back(16'(i));
    run(0, 220, 1'b0);
    n_checks++;
    if (bus.dropped_count !== 8'd200) begin n_fail++; $display("FAIL sat_dropped200: got %0d want 200", bus.dropped_count); end
    for (int i = 0; i < 100; i++) push_q.push_back(16'(i));
    run(0, 104, 1'b0);
    n_checks += 2;
    if (bus.dropped_count !== 8'd255) begin n_fail++; $display("FAIL sat_dropped255: got %0d want 255", bus.dropped_count); end
    if (bus.overflow !== 1'b1)        begin n_fail++; $display("FAIL sat_overflow: got %b want 1", bus.overflow); end
  endtask

  task automatic test_spurious_done();
    logic [7:0] exp[$] = '{8'hA5, 8'h3C, 8'hC3};
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.tx_done = 1'b1;
      @(negedge clk);
      bus.tx_done = 1'b0;
      n_checks++;
      if (bus.transmit !== 1'b0) begin n_fail++; $display("FAIL spur_idle_tx%0d: got %b want 0", i, bus.transmit); end
    end
    run(0, 4, 1'b0);
    n_checks++;
    if (got_q.size() !== 0) begin n_fail++; $display("FAIL spur_idle_count: got %0d bytes want 0", got_q.size()); end
    stretch_done   = 1'b1;
    push_q.push_back(16'h3CC3);
    extra_done_cyc = cyc + 3;
    run(3, 200, 1'b0);
    stretch_done   = 1'b0;
    extra_done_cyc = -1;
    run(0, 10, 1'b0);
    n_checks++;
    if (got_q.size() !== 3) begin n_fail++; $display("FAIL spur_count: got %0d bytes want 3", got_q.size()); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (got_q[i] !== exp[i]) begin n_fail++; $display("FAIL spur_byte%0d: got %h want %h", i, got_q[i], exp[i]); end
    end
  endtask

  task automatic test_rst_mid_frame();
    logic [7:0] exp[$] = '{8'hA5, 8'h5A, 8'h69};
    model_reset();
    push_q = '{16'hABCD, 16'h1111, 16'h2222, 16'h3333};
    run(2, 200, 1'b1);
    n_checks++;
    if (got_q.size() !== 2 || got_q[1] !== 8'hAB) begin n_fail++; $display("FAIL rst_msb: got %0d bytes, last %h, want 2 bytes ending ab", got_q.size(), got_q[got_q.size()-1]); end
    rst             = 1'b1;
    bus.count_valid = 1'b0;
    @(negedge clk);
    n_checks += 6;
    if (bus.transmit !== 1'b0)      begin n_fail++; $display("FAIL rst_transmit: got %b want 0", bus.transmit); end
    if (bus.tx_byte !== 8'h00)      begin n_fail++; $display("FAIL rst_tx_byte: got %h want 00", bus.tx_byte); end
    if (bus.frame_active !== 1'b0)  begin n_fail++; $display("FAIL rst_frame_active: got %b want 0", bus.frame_active); end
    if (bus.count_ready !== 1'b1)   begin n_fail++; $display("FAIL rst_count_ready: got %b want 1", bus.count_ready); end
    if (bus.overflow !== 1'b0)      begin n_fail++; $display("FAIL rst_overflow: got %b want 0", bus.overflow); end
    if (bus.dropped_count !== 8'd0) begin n_fail++; $display("FAIL rst_dropped: got %0d want 0", bus.dropped_count); end
    rst = 1'b0;
    model_reset();
    run(0, 20, 1'b0);
    n_checks++;
    if (got_q.size() !== 0) begin n_fail++; $display("FAIL rst_flushed: got %0d bytes want 0", got_q.size()); end
    push_q.push_back(16'h5A69);
    run(3, 200, 1'b0);
    n_checks++;
    if (got_q.size() !== 3) begin n_fail++; $display("FAIL rst_fresh_count: got %0d bytes want 3", got_q.size()); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (got_q[i] !== exp[i]) begin n_fail++; $display("FAIL rst_fresh_byte%0d: got %h want %h", i, got_q[i], exp[i]); end
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus.count_valid = 1'b0;
    bus.count_data  = 16'd0;
    bus.tx_busy     = 1'b0;
    bus.tx_done     = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_reset();
    test_full();
    test_reset();
    test_saturate();
    test_reset();
    test_spurious_done();
    test_reset();
    test_rst_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pmt_count_serializer.md
# pmt_count_serializer

Byte-framing stage that sits directly upstream of the UART transmitter in the PMT timebin counting design. It buffers 16-bit timebin photon counts from the counter logic in a small FIFO. It emits each count as a 3-byte frame: sync byte, count MSB, count LSB. Bytes go to the UART one at a time using the UART's transmit/tx_byte/tx_Done handshake.

## Interface
- FIFO_DEPTH, 16, count-word FIFO depth; power of two, 2..256
- SYNC_BYTE, 8'hA5, first byte of every frame
- clk  input  1  master clock, shared with the UART
- rst  input  1  synchronous, active-high reset
- count_valid  input  1  one-cycle strobe: count_data holds a finished timebin count
- count_data  input  16  timebin count
- count_ready  output  1  high when the FIFO is not full (informational; the source never stalls)
- transmit  output  1  one-cycle request to the UART to send tx_byte
- tx_byte  output  8  byte to the UART
- tx_busy  input  1  UART is_transmitting
- tx_done  input  1  UART tx_Done, a one-cycle pulse after the stop bits
- overflow  output  1  sticky; set when a count is dropped
- dropped_count  output  8  saturating count of dropped words
- frame_active  output  1  high from frame start until tx_done of the LSB

## Operation
- Reset values: transmit=0, tx_byte=0, overflow=0, dropped_count=0, frame_active=0, count_ready=1, FIFO empty, FSM in IDLE, byte index 0.
- FIFO
  - Synchronous, with a registered occupancy counter of width log2(FIFO_DEPTH)+1.
  - Push when count_valid=1 and the FIFO is not full.
  - If count_valid=1 while full (occupancy sampled before the edge), the word is dropped. overflow<=1 and dropped_count increments, saturating at 255.
  - A pop in the same cycle does not rescue a push attempted while full.
  - A simultaneous push and pop on a non-full FIFO leaves the occupancy unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, SEND, WAIT_DONE.
  - IDLE: if the FIFO is non-empty and tx_busy=0, pop the head word into a 16-bit holding register. Set byte index to 0, frame_active<=1, go to SEND.
  - SEND: transmit<=1 for exactly one cycle. tx_byte<= SYNC_BYTE, count[15:8] or count[7:0] for byte index 0, 1 or 2. Go to WAIT_DONE.
  - WAIT_DONE: hold tx_byte stable and wait for tx_done=1.
    - If byte index < 2: increment the index and go to SEND.
    - If byte index = 2: frame_active<=0 and go to IDLE.
- tx_done is ignored in IDLE and SEND. tx_busy is checked only in IDLE.
- overflow and dropped_count clear only on rst.

## Timing
- The pop edge is at cycle N; transmit=1 during cycle N+1.
- tx_byte is valid in the same cycle as transmit and holds until the next SEND.
- tx_done is high in cycle M, so transmit for the next byte is high in cycle M+2. The UART is already back in its idle state by then.
- After the LSB's tx_done, the next frame may start with a pop at the following edge. Minimum latency from count_valid on an empty FIFO with an idle UART to the first transmit is 3 cycles: push, pop, transmit.
- count_ready reflects the registered occupancy, so it deasserts the cycle after the 16th un-popped word is stored.
- rst mid-frame: the FSM returns to IDLE and the FIFO is flushed. The holding register content is discarded, with no partial frame completion. transmit=0 on the cycle after the rst edge.

## Test plan
- Single count_data=16'h1234 with the UART model idle. Required response:
  - Exactly 3 transmit pulses with tx_byte A5, 12, 34.
  - Each pulse occurs 2 cycles after the previous tx_done.
  - frame_active falls after the third tx_done.
- 4 back-to-back counts 0001, 00FF, 8000, FFFF on consecutive cycles. Required response: 12 bytes in order A5 00 01 A5 00 FF A5 80 00 A5 FF FF, and overflow stays 0.
- Hold tx_busy=1 and push 18 words. Required response:
  - 16 words are stored; count_ready=0 after the 16th.
  - overflow=1 and dropped_count=2.
  - After releasing tx_busy, the first 16 words are sent in FIFO order.
- Push 300 words into a full FIFO. Required response: dropped_count saturates at 255 with no wrap.
- Spurious tx_done pulses in IDLE, and a tx_done in the same cycle as SEND. Required response: neither produces an extra transmit nor advances the byte index.
- Assert rst after the MSB's transmit, with 3 words queued. Required response:
  - No LSB is sent; all outputs return to their reset values.
  - A new word pushed after reset produces a complete fresh frame.
